// File: rtl/scan_sequencer_3_8.sv
// Timed slot scanner driving a 3-to-8 decoder: one masked slot enabled at a time, DWELL cycles each.
// Latency: start sampled in cycle N gives en=1 in cycle N+1; sel/en/busy registered, strobes decode state only.
// Backpressure: none; start ignored while busy, stop ends the scan after the current slot completes.
// Optional: define SCAN_BLANK_EN to insert one en=0 BLANK cycle after every slot that continues the scan.
module scan_sequencer_3_8 #(
  parameter int DWELL   = 4,
  parameter int DWELL_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       en,
  output logic       busy,
  output logic       slot_done,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam logic [DWELL_W-1:0] LAST_CNT = DWELL_W'(DWELL - 1);

  // Index of the lowest set bit; only used on non-zero masks.
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Cyclic upward search starting at cur+1; cur itself is the last candidate,
  // so a single-bit mask returns cur (which the caller sees as a wrap).
  function automatic logic [2:0] next_idx(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] j;
    idx = cur;
    for (int k = 8; k >= 1; k--) begin
      j = cur + 3'(k);
      if (m[j]) idx = j;
    end
    return idx;
  endfunction

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic               r_en, r_busy;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
  logic               r_stop_pend, w_stop_nxt;
  logic [7:0]         r_mask, w_mask_nxt;
`ifdef SCAN_BLANK_EN
  logic [2:0]         r_nsel, w_nsel_nxt;
`endif

  logic       w_last;
  logic       w_wrap;
  logic [2:0] w_nidx;
  logic       w_go;
  logic [2:0] w_go_idx;

  // Slot-end and frame-end decodes from registered state only.
  always_comb begin
    w_last = (r_state == S_RUN) && (r_cnt == LAST_CNT);
    w_nidx = next_idx(r_mask, r_sel);
    w_wrap = (w_nidx <= r_sel);
  end

  assign sel        = r_sel;
  assign en         = r_en;
  assign busy       = r_busy;
  assign slot_done  = w_last;
  assign frame_done = w_last && w_wrap;

  // Next-state logic: frame start, dwell counting, slot advance and termination.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_stop_nxt  = r_stop_pend;
    w_mask_nxt  = r_mask;
    w_go        = 1'b0;
    w_go_idx    = r_sel;
`ifdef SCAN_BLANK_EN
    w_nsel_nxt  = r_nsel;
`endif
    case (r_state)
      S_IDLE: begin
        w_stop_nxt = 1'b0;
        if (start && !stop && (mask != 8'h00)) begin
          w_state_nxt = S_RUN;
          w_mask_nxt  = mask;
          w_sel_nxt   = lowest_idx(mask);
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        if (stop) w_stop_nxt = 1'b1;
        if (!w_last) begin
          w_cnt_nxt = r_cnt + DWELL_W'(1);
        end else begin
          w_cnt_nxt = '0;
          if (r_stop_pend || stop) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
          end else if (w_wrap && mode) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
          end else if (w_wrap) begin
            // Continuous mode: the next frame uses the mask as it is now.
            w_mask_nxt = mask;
            if (mask == 8'h00) begin
              w_state_nxt = S_IDLE;
              w_stop_nxt  = 1'b0;
            end else begin
              w_go     = 1'b1;
              w_go_idx = lowest_idx(mask);
            end
          end else begin
            w_go     = 1'b1;
            w_go_idx = w_nidx;
          end
          if (w_go) begin
`ifdef SCAN_BLANK_EN
            // Park the next slot; sel keeps the old slot through BLANK.
            w_state_nxt = S_BLANK;
            w_nsel_nxt  = w_go_idx;
`else
            w_state_nxt = S_RUN;
            w_sel_nxt   = w_go_idx;
`endif
          end
        end
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: begin
        w_cnt_nxt = '0;
        if (r_stop_pend || stop) begin
          w_state_nxt = S_IDLE;
          w_stop_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_RUN;
          w_sel_nxt   = r_nsel;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_stop_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame without strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sel       <= 3'd0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_mask      <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_en        <= (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cnt       <= w_cnt_nxt;
      r_stop_pend <= w_stop_nxt;
      r_mask      <= w_mask_nxt;
    end
  end

`ifdef SCAN_BLANK_EN
  // Pending slot index carried across the BLANK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_nsel <= 3'd0;
    else        r_nsel <= w_nsel_nxt;
  end
`endif

endmodule
